// File: rtl/scam_multi_reader_types.sv
// Shared types for the multi-channel blocking SCAM reader.
// Optional build macro: SCAM_NB_TRY_EN (non-blocking try-read on each channel).
package scam_multi_reader_types;

    typedef enum logic [0:0] {
        ST_READ  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_INIT_VAR = 4;

    // Channel index width; a single channel still needs one index bit.
    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // One-hot decode: bit 'pos' of the decoded vector for index 'idx'.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return (idx == pos);
    endfunction

endpackage

// File: rtl/scam_onehot_notify.sv
// Registered one-hot input-notify vector. Driven from the reader's next state
// so the notify bit moves to the next channel in the cycle after a transfer.
module scam_onehot_notify
    import scam_multi_reader_types::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = idx_width(DEF_NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  state_e            state_d_i,
    input  logic [IDX_W-1:0]  ch_idx_d_i,
    input  logic              enable_i,
    output logic [NUM_CH-1:0] notify_o
);

    logic [NUM_CH-1:0] notify_d;
    logic [NUM_CH-1:0] notify_q;

    // Decode next channel index into a one-hot vector, zero while writing.
    always_comb begin
        notify_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (enable_i && (state_d_i == ST_READ)) begin
                notify_d[i] = onehot_bit(32'(ch_idx_d_i), i);
            end else begin
                notify_d[i] = 1'b0;
            end
        end
    end

    // Notify register; reset offers channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            notify_q <= NUM_CH'(1);
        end else begin
            notify_q <= notify_d;
        end
    end

    assign notify_o = notify_q;

endmodule

// File: rtl/scam_multi_blocking_reader.sv
// Multi-channel SCAM reader: reads NUM_CH input channels in fixed order,
// accumulates them (two's complement, wrapping), then offers the sum on a
// blocking output port. The accumulator persists across rounds.
// Optional build macro: SCAM_NB_TRY_EN -- each read becomes a try-read that
// skips a channel whose sync is low instead of blocking on it.
module scam_multi_blocking_reader
    import scam_multi_reader_types::*;
#(
    parameter int                 NUM_CH   = DEF_NUM_CH,
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  INIT_VAR = DATA_W'(DEF_INIT_VAR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] b_in,
    input  logic [NUM_CH-1:0]        b_in_sync,
    output logic [NUM_CH-1:0]        b_in_notify,
    output logic [DATA_W-1:0]        b_out,
    input  logic                     b_out_sync,
    output logic                     b_out_notify,
    output logic                     nb_result,
    output logic [DATA_W-1:0]        var_out
);

    localparam int IDX_W = idx_width(NUM_CH);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
    logic [DATA_W-1:0]   var_q, var_d;
    logic                nb_q, nb_d;
    logic [DATA_W-1:0]   b_out_q, b_out_d;
    logic                b_out_notify_q, b_out_notify_d;

    logic [DATA_W-1:0]   cur_data_s;
    logic                cur_sync_s;
    logic                last_ch_s;
    logic                advance_s;

    // Select the currently addressed channel's data and sync.
    always_comb begin
        cur_data_s = b_in[32'(ch_idx_q) * DATA_W +: DATA_W];
        cur_sync_s = b_in_sync[ch_idx_q];
        last_ch_s  = (ch_idx_q == IDX_W'(NUM_CH - 1));
    end

    // Next-state logic for the read/accumulate/write round.
    always_comb begin
        state_d        = state_q;
        ch_idx_d       = ch_idx_q;
        var_d          = var_q;
        nb_d           = nb_q;
        b_out_d        = b_out_q;
        b_out_notify_d = b_out_notify_q;
        advance_s      = 1'b0;

        case (state_q)
            ST_READ: begin
`ifdef SCAM_NB_TRY_EN
                // Try-read: always move on; nb_result reports whether data came.
                advance_s = 1'b1;
                nb_d      = cur_sync_s;
                if (cur_sync_s) begin
                    var_d = var_q + cur_data_s;
                end else begin
                    var_d = var_q;
                end
`else
                // Blocking read: stay on this channel until its producer syncs.
                if (cur_sync_s) begin
                    advance_s = 1'b1;
                    var_d     = var_q + cur_data_s;
                    nb_d      = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
`endif
                if (advance_s && last_ch_s) begin
                    state_d        = ST_WRITE;
                    b_out_d        = var_d;
                    b_out_notify_d = 1'b1;
                end else if (advance_s) begin
                    ch_idx_d = ch_idx_q + IDX_W'(1);
                end else begin
                    ch_idx_d = ch_idx_q;
                end
            end
            ST_WRITE: begin
                if (b_out_sync) begin
                    state_d        = ST_READ;
                    ch_idx_d       = '0;
                    b_out_notify_d = 1'b0;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d        = ST_READ;
                ch_idx_d       = '0;
                b_out_notify_d = 1'b0;
            end
        endcase
    end

    // Round state, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_READ;
            ch_idx_q       <= '0;
            var_q          <= INIT_VAR;
            nb_q           <= 1'b0;
            b_out_q        <= '0;
            b_out_notify_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_idx_q       <= ch_idx_d;
            var_q          <= var_d;
            nb_q           <= nb_d;
            b_out_q        <= b_out_d;
            b_out_notify_q <= b_out_notify_d;
        end
    end

    scam_onehot_notify #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_notify (
        .clk        (clk),
        .rst        (rst),
        .state_d_i  (state_d),
        .ch_idx_d_i (ch_idx_d),
        .enable_i   (1'b1),
        .notify_o   (b_in_notify)
    );

    assign b_out        = b_out_q;
    assign b_out_notify = b_out_notify_q;
    assign nb_result    = nb_q;
    assign var_out      = var_q;

endmodule
